mat_seq_ctrl: RTL and testbench

Sequencer for the 9-entry byte matrix buffer that feeds the 3x3 matrix compute unit. It accepts a byte stream with a valid/ready handshake and drives explicit write strobes and addresses into the buffer. Once a full frame is loaded, it pulses start to the consumer and back-pressures the stream until the consumer reports done or a watchdog expires. It replaces free-running wrap-around filling with frame-accurate sequencing.

---
 rtl/mat_pkg.sv | 15 +
 rtl/mat_seq_ctrl_wdog_cnt.sv | 27 ++
 rtl/mat_seq_ctrl.sv | 107 ++++++++++
 tb/tb_mat_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared constants and state encoding for the matrix buffer sequencer.
package mat_pkg;

  localparam int N_ELEM  = 9;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 4;
  localparam int TIMEOUT = 255;

  typedef enum logic [1:0] {
    FILL,
    START,
    WAIT
  } state_t;

endpackage

// File: rtl/mat_seq_ctrl_wdog_cnt.sv
// Clearable up-counter with a terminal-count flag at TIMEOUT-1.
module wdog_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [W-1:0] wd_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      wd_q <= '0;
    else if (i_clr)
      wd_q <= '0;
    else if (i_en)
      wd_q <= wd_q + W'(1);
  end

  assign o_tc = (wd_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mat_seq_ctrl.sv
// Frame sequencer: loads N_ELEM bytes into the matrix buffer,
// pulses start, then holds off the stream until done or timeout.
module mat_seq_ctrl #(
  parameter int N_ELEM  = mat_pkg::N_ELEM,
  parameter int DATA_W  = mat_pkg::DATA_W,
  parameter int TIMEOUT = mat_pkg::TIMEOUT
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  input  logic [DATA_W-1:0]         i_data,
  output logic                      o_ready,
  input  logic                      i_abort,
  output logic                      o_wr_en,
  output logic [mat_pkg::ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0]         o_wr_data,
  output logic                      o_start,
  input  logic                      i_done,
  output logic                      o_busy,
  output logic                      o_err,
  output logic [7:0]                o_frame_cnt
);

  import mat_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ELEM - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q;
  logic [7:0]        frame_q;
  logic              err_set;
  logic              frame_inc;
  logic              wd_tc;

  assign o_ready     = (state_q == FILL);
  assign o_wr_en     = i_valid & o_ready & ~i_abort;
  assign o_wr_addr   = cnt_q;
  assign o_wr_data   = i_data;
  assign o_start     = (state_q == START);
  assign o_busy      = (state_q == START) | (state_q == WAIT);
  assign o_err       = err_q;
  assign o_frame_cnt = frame_q;

  // Held clear outside WAIT so it starts from zero on entry.
  wdog_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_clr(i_abort | (state_q != WAIT)),
    .i_en (state_q == WAIT),
    .o_tc (wd_tc)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_set   = 1'b0;
    frame_inc = 1'b0;
    if (i_abort) begin
      state_d = FILL;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (o_wr_en) begin
            if (cnt_q == LAST) begin
              state_d = START;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        START: state_d = WAIT;
        WAIT: begin
          if (i_done) begin
            state_d   = FILL;
            frame_inc = 1'b1;
          end else if (wd_tc) begin
            state_d = FILL;
            err_set = 1'b1;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (err_set)
        err_q <= 1'b1;
      if (frame_inc)
        frame_q <= frame_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_mat_seq_ctrl.sv
// Directed bench for mat_seq_ctrl with a short watchdog.
module tb_mat_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic       i_abort;
  logic       o_wr_en;
  logic [3:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_start;
  logic       i_done;
  logic       o_busy;
  logic       o_err;
  logic [7:0] o_frame_cnt;

  int total = 0;
  int bad   = 0;

  mat_seq_ctrl #(
    .N_ELEM (9),
    .DATA_W (8),
    .TIMEOUT(4)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_ready    (o_ready),
    .i_abort    (i_abort),
    .o_wr_en    (o_wr_en),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_start    (o_start),
    .i_done     (i_done),
    .o_busy     (o_busy),
    .o_err      (o_err),
    .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Streams n back-to-back bytes from address a0; the last one
  // completes the frame, so the following cycle must be START.
  task automatic fill(input int a0, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_data  = base + 8'(i);
      #1;
      chk("wr_en", o_wr_en, 1);
      chk("wr_addr", o_wr_addr, a0 + i);
      chk("wr_data", o_wr_data, base + 8'(i));
      chk("no_start", o_start, 0);
      tick();
    end
    i_valid = 1'b0;
    #1;
    chk("start", o_start, 1);
    chk("start_rdy", o_ready, 0);
    chk("start_busy", o_busy, 1);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;
    i_abort = 1'b0;
    i_done  = 1'b0;
    #1;
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_start", o_start, 0);
    chk("rst_err", o_err, 0);
    chk("rst_frame", o_frame_cnt, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    tick();

    // Frame 1: 0x11..0x99 held valid, start on the cycle after
    for (int i = 0; i < 9; i++) begin
      i_valid = 1'b1;
      i_data  = 8'h11 * 8'(i + 1);
      #1;
      chk("f1_wr_en", o_wr_en, 1);
      chk("f1_addr", o_wr_addr, i);
      chk("f1_data", o_wr_data, 8'h11 * 8'(i + 1));
      chk("f1_nostart", o_start, 0);
      tick();
    end
    i_data = 8'hAA;
    #1;
    chk("f1_start", o_start, 1);
    chk("f1_rdy0", o_ready, 0);
    chk("f1_nowr", o_wr_en, 0);
    tick();
    chk("w0_start", o_start, 0);
    chk("w0_busy", o_busy, 1);
    chk("w0_nowr", o_wr_en, 0);
    tick();
    tick();
    i_done = 1'b1;
    tick();
    i_done  = 1'b0;
    i_data  = 8'hAB;
    #1;
    chk("d_ready", o_ready, 1);
    chk("d_frame", o_frame_cnt, 1);
    chk("d_busy", o_busy, 0);
    chk("d_wr_en", o_wr_en, 1);
    chk("d_addr", o_wr_addr, 0);
    chk("d_data", o_wr_data, 8'hAB);
    tick();

    // Gapped stream completes the frame started above
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1;
      i_data  = 8'(8'h40 + k);
      #1;
      chk("g_wr_en", o_wr_en, 1);
      chk("g_addr", o_wr_addr, k);
      chk("g_nostart", o_start, 0);
      tick();
      i_valid = 1'b0;
      #1;
      chk("g_nowr", o_wr_en, 0);
      if (k < 8) begin
        chk("g_hold", o_wr_addr, k + 1);
        chk("g_gap_nostart", o_start, 0);
      end
    end
    chk("g_start", o_start, 1);
    tick();

    // Timeout: four WAIT cycles, i_done in FILL ignored afterwards
    for (int w = 0; w < 4; w++) begin
      #1;
      chk("to_busy", o_busy, 1);
      chk("to_err0", o_err, 0);
      tick();
    end
    i_done = 1'b1;
    #1;
    chk("to_fill", o_busy, 0);
    chk("to_ready", o_ready, 1);
    chk("to_err1", o_err, 1);
    chk("to_frame", o_frame_cnt, 1);
    tick();
    i_done = 1'b0;
    chk("fill_done_ign", o_frame_cnt, 1);

    // Frame after error proceeds normally
    fill(0, 9, 8'h60);
    tick();
    i_done = 1'b1;
    tick();
    i_done = 1'b0;
    #1;
    chk("e_frame", o_frame_cnt, 2);
    chk("e_err", o_err, 1);
    chk("e_ready", o_ready, 1);

    // Abort with valid after five bytes
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1;
      i_data  = 8'(8'h70 + i);
      #1;
      chk("a_addr", o_wr_addr, i);
      tick();
    end
    i_abort = 1'b1;
    #1;
    chk("a_nowr", o_wr_en, 0);
    tick();
    i_abort = 1'b0;
    fill(0, 9, 8'h80);
    tick();
    i_abort = 1'b1;
    i_done  = 1'b1;
    #1;
    chk("aw_busy", o_busy, 1);
    tick();
    i_abort = 1'b0;
    i_done  = 1'b0;
    #1;
    chk("aw_fill", o_busy, 0);
    chk("aw_frame", o_frame_cnt, 2);
    chk("aw_err", o_err, 1);

    // Async reset between edges while in WAIT
    fill(0, 9, 8'h90);
    tick();
    #1;
    chk("r_inwait", o_busy, 1);
    i_rst = 1'b1;
    #1;
    chk("ar_ready", o_ready, 1);
    chk("ar_busy", o_busy, 0);
    chk("ar_err", o_err, 0);
    chk("ar_frame", o_frame_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
